// File: rtl/axi_build_info.sv
// AXI4-Lite status slave: build identity (version, date, git hash), 64-bit uptime
// counter with a coherent high-half shadow, and a bank of byte-writable scratch registers.
module axi_build_info #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 6,
    parameter logic [31:0] VERSION_MAJOR = 32'd1,
    parameter logic [31:0] VERSION_MINOR = 32'd0,
    parameter logic [31:0] VERSION_BUILD = 32'd0,
    parameter logic [31:0] VERSION_DATE  = 32'h071B07E6,
    parameter logic [31:0] GIT_HASH      = 32'h0,
    parameter int          NUM_SCRATCH   = 4
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    input  logic [2:0]              S_AXI_ARPROT,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;

    rd_state_t             rd_state;
    wr_state_t             wr_state;
    logic [63:0]           uptime;
    logic [31:0]           uptime_shadow;
    logic [DATA_WIDTH-1:0] scratch [NUM_SCRATCH];
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [31:0]           rd_word;
    logic [31:0]           wr_word;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_err;
    logic                  wr_hit;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign rd_word = 32'(rd_idx);
    assign wr_word = 32'(wr_idx);

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) uptime <= '0;
        else            uptime <= uptime + 64'd1;
    end

    always_comb begin
        rd_value = '0;
        rd_err   = 1'b0;
        case (rd_word)
            32'd0: rd_value = VERSION_MAJOR;
            32'd1: rd_value = VERSION_MINOR;
            32'd2: rd_value = VERSION_BUILD;
            32'd3: rd_value = VERSION_DATE;
            32'd4: rd_value = GIT_HASH;
            32'd5: rd_value = uptime[31:0];
            32'd6: rd_value = uptime_shadow;
            32'd7: rd_value = 32'(NUM_SCRATCH);
            default: begin
                rd_err = 1'b1;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (rd_word == 32'(8 + i)) begin
                        rd_value = scratch[i];
                        rd_err   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_word == 32'(8 + i)) wr_hit = 1'b1;
        end
    end

    // Reading UPTIME_LO snapshots the high half so a following HI read is coherent.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            rd_idx        <= '0;
            uptime_shadow <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rd_idx        <= S_AXI_ARADDR[ADDR_WIDTH-1:2];
                        S_AXI_ARREADY <= 1'b0;
                        rd_state      <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    S_AXI_RDATA  <= rd_value;
                    S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    S_AXI_RVALID <= 1'b1;
                    if (rd_word == 32'd5) uptime_shadow <= uptime[63:32];
                    rd_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rd_state      <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; COMMIT starts once both are held.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        wr_idx        <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                        S_AXI_AWREADY <= 1'b0;
                    end
                    if (S_AXI_WVALID && S_AXI_WREADY) begin
                        wdata_q      <= S_AXI_WDATA;
                        wstrb_q      <= S_AXI_WSTRB;
                        S_AXI_WREADY <= 1'b0;
                    end
                    if ((!S_AXI_AWREADY || S_AXI_AWVALID) && (!S_AXI_WREADY || S_AXI_WVALID))
                        wr_state <= WR_COMMIT;
                end
                WR_COMMIT: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (wr_word == 32'(8 + i)) begin
                            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                                if (wstrb_q[b]) scratch[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                    S_AXI_BRESP  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                    S_AXI_BVALID <= 1'b1;
                    wr_state     <= WR_RESP;
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wr_state      <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end
endmodule
